// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the generic pipeline stage register.
// Optional build macro: PIPE_STAGE_REG_STATS_EN (stall-cycle counter in pipe_stage_reg).
package pipe_stage_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_EMPTY = 2'd0;
   localparam state_t ST_ONE   = 2'd1;
   localparam state_t ST_FULL  = 2'd2;

   localparam int unsigned STALL_CNT_W = 32;

   // Bit offset of field idx inside a packed entry; use as entry[field_lsb(k, S) +: S].
   function automatic int unsigned field_lsb(input int unsigned idx,
                                             input int unsigned size_data);
      return idx * size_data;
   endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One entry of storage (data plus valid) with load / clear / hold control.
module pipe_stage_slot #(
   parameter int unsigned W = 32
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   // Clear wins over load so a flush always leaves the slot empty.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_clear) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_load) begin
         o_valid <= i_valid;
         o_data  <= i_data;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic N-field pipeline stage register with valid/ready handshake, flush
// and a two-entry skid buffer; upstream ready never depends on downstream ready.
// Optional build macro: PIPE_STAGE_REG_STATS_EN adds o_stall_cycles.
module pipe_stage_reg
   import pipe_stage_pkg::*;
#(
   parameter  int unsigned SIZE_DATA  = 8,
   parameter  int unsigned NUM_FIELDS = 4,
   localparam int unsigned W          = SIZE_DATA * NUM_FIELDS
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_enable,
   input  logic         i_flush,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   input  logic         i_ready
`ifdef PIPE_STAGE_REG_STATS_EN
   ,
   output logic [STALL_CNT_W-1:0] o_stall_cycles
`endif
);

   state_t         state;
   state_t         state_nxt;
   logic           main_valid;
   logic [W-1:0]   main_q;
   logic           skid_valid;
   logic [W-1:0]   skid_q;
   logic           main_load;
   logic           main_clear;
   logic           main_vin;
   logic [W-1:0]   main_d;
   logic           skid_load;
   logic           skid_clear;
   logic           accept;
   logic           drain;

   // Outputs come straight from registers, gated only by the stage enable.
   assign o_data  = main_q;
   assign o_valid = main_valid & i_enable;
   assign o_ready = (state != ST_FULL) & i_enable;
   assign accept  = i_valid & o_ready;
   assign drain   = o_valid & i_ready;

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_reset) state <= ST_EMPTY;
      else          state <= state_nxt;
   end

   // Next-state and slot control.
   always_comb begin
      state_nxt  = state;
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_vin   = 1'b1;
      main_d     = i_data;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (i_enable) begin
         if (i_flush) begin
            state_nxt  = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
         end else begin
            case (state)
               ST_EMPTY: begin
                  if (accept) begin
                     state_nxt = ST_ONE;
                     main_load = 1'b1;
                  end
               end
               ST_ONE: begin
                  if (accept && drain) begin
                     main_load = 1'b1;
                  end else if (accept) begin
                     state_nxt = ST_FULL;
                     skid_load = 1'b1;
                  end else if (drain) begin
                     state_nxt  = ST_EMPTY;
                     main_clear = 1'b1;
                  end
               end
               ST_FULL: begin
                  // Skid moves up into main; it never bypasses the older entry.
                  if (drain) begin
                     state_nxt  = ST_ONE;
                     main_load  = 1'b1;
                     main_vin   = skid_valid;
                     main_d     = skid_q;
                     skid_clear = 1'b1;
                  end
               end
               default: begin
                  state_nxt  = ST_EMPTY;
                  main_clear = 1'b1;
                  skid_clear = 1'b1;
               end
            endcase
         end
      end
   end

   pipe_stage_slot #(.W(W)) u_main (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (main_load),
      .i_clear (main_clear),
      .i_valid (main_vin),
      .i_data  (main_d),
      .o_valid (main_valid),
      .o_data  (main_q)
   );

   pipe_stage_slot #(.W(W)) u_skid (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (skid_load),
      .i_clear (skid_clear),
      .i_valid (1'b1),
      .i_data  (i_data),
      .o_valid (skid_valid),
      .o_data  (skid_q)
   );

`ifdef PIPE_STAGE_REG_STATS_EN
   // Saturating count of enabled cycles where downstream holds off a valid entry.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_stall_cycles <= '0;
      end else if (o_valid && !i_ready && (o_stall_cycles != '1)) begin
         o_stall_cycles <= o_stall_cycles + STALL_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Honours PIPE_STAGE_REG_STATS_EN to exercise the stall counter.
module tb_pipe_stage_reg;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_enable;
   logic        i_flush;
   logic        i_valid;
   logic [31:0] i_data;
   logic        o_ready;
   logic        o_valid;
   logic [31:0] o_data;
   logic        i_ready;
`ifdef PIPE_STAGE_REG_STATS_EN
   logic [31:0] o_stall_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   pipe_stage_reg #(.SIZE_DATA(8), .NUM_FIELDS(4)) dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .i_flush  (i_flush),
      .i_valid  (i_valid),
      .i_data   (i_data),
      .o_ready  (o_ready),
      .o_valid  (o_valid),
      .o_data   (o_data),
      .i_ready  (i_ready)
`ifdef PIPE_STAGE_REG_STATS_EN
      ,
      .o_stall_cycles (o_stall_cycles)
`endif
   );

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held two cycles while junk is offered upstream.
      i_reset = 1'b0; i_enable = 1'b1; i_flush = 1'b0;
      i_valid = 1'b1; i_data = 32'hDEADBEEF; i_ready = 1'b1;
      tick(); tick();
      i_reset = 1'b1; i_valid = 1'b0;
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_data",  o_data, 32'd0);

      // Streaming at full rate.
      i_ready = 1'b1; i_valid = 1'b1; i_data = 32'h01020304;
      tick();
      chk("str0_data", o_data, 32'h01020304);
      chk("str0_valid", 32'(o_valid), 32'd1);
      chk("str0_ready", 32'(o_ready), 32'd1);
      i_data = 32'h05060708;
      tick();
      chk("str1_data", o_data, 32'h05060708);
      chk("str1_valid", 32'(o_valid), 32'd1);
      chk("str1_ready", 32'(o_ready), 32'd1);
      i_data = 32'h090A0B0C;
      tick();
      chk("str2_data", o_data, 32'h090A0B0C);
      chk("str2_valid", 32'(o_valid), 32'd1);
      chk("str2_ready", 32'(o_ready), 32'd1);
      i_valid = 1'b0;
      tick();
      chk("str_end_valid", 32'(o_valid), 32'd0);

      // Backpressure fills the skid buffer, then drains in order.
      i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h11;
      tick();
      chk("bp_a_data", o_data, 32'h11);
      chk("bp_a_ready", 32'(o_ready), 32'd1);
      i_data = 32'h22;
      tick();
      chk("bp_full_ready", 32'(o_ready), 32'd0);
      chk("bp_full_data", o_data, 32'h11);
      chk("bp_full_valid", 32'(o_valid), 32'd1);
      i_valid = 1'b0;
      tick();
      chk("bp_hold_data", o_data, 32'h11);
      i_ready = 1'b1;
      #1;
      chk("bp_rel_data", o_data, 32'h11);
      chk("bp_rel_ready", 32'(o_ready), 32'd0);
      tick();
      chk("bp_b_data", o_data, 32'h22);
      chk("bp_b_valid", 32'(o_valid), 32'd1);
      chk("bp_b_ready", 32'(o_ready), 32'd1);
      tick();
      chk("bp_empty_valid", 32'(o_valid), 32'd0);

      // Flush from FULL with a new entry offered.
      i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hAA;
      tick();
      i_data = 32'hBB;
      tick();
      chk("fl_full_ready", 32'(o_ready), 32'd0);
      i_flush = 1'b1; i_data = 32'h33;
      tick();
      i_flush = 1'b0; i_valid = 1'b0;
      #1;
      chk("fl_valid", 32'(o_valid), 32'd0);
      chk("fl_ready", 32'(o_ready), 32'd1);
      chk("fl_data", o_data, 32'd0);
      i_ready = 1'b1;
      tick();
      chk("fl_no_c_valid", 32'(o_valid), 32'd0);
      chk("fl_no_c_data", o_data, 32'd0);

      // Flush from ONE discards an entry accepted in the same cycle.
      i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h55;
      tick();
      i_flush = 1'b1; i_data = 32'h66;
      tick();
      i_flush = 1'b0; i_valid = 1'b0;
      #1;
      chk("fl1_valid", 32'(o_valid), 32'd0);
      chk("fl1_data", o_data, 32'd0);

      // Enable freeze while holding one entry.
      i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h44;
      tick();
      i_enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         i_ready = (i % 2) == 0;
         i_valid = (i % 2) != 0;
         i_flush = (i == 1);
         i_data  = 32'h99;
         #1;
         chk("frz_valid", 32'(o_valid), 32'd0);
         chk("frz_ready", 32'(o_ready), 32'd0);
         tick();
      end
      i_enable = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
      #1;
      chk("frz_ret_valid", 32'(o_valid), 32'd1);
      chk("frz_ret_data", o_data, 32'h44);
      chk("frz_ret_ready", 32'(o_ready), 32'd1);
      i_ready = 1'b1;
      tick();
      chk("frz_drain_valid", 32'(o_valid), 32'd0);

      // Mid-operation reset drops held entries.
      i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h5A;
      tick();
      i_reset = 1'b0; i_valid = 1'b0;
      tick();
      i_reset = 1'b1;
      #1;
      chk("mrst_valid", 32'(o_valid), 32'd0);
      chk("mrst_data", o_data, 32'd0);

`ifdef PIPE_STAGE_REG_STATS_EN
      // Stall counter: five stalled cycles, unaffected by flush, cleared by reset.
      i_reset = 1'b0;
      tick();
      i_reset = 1'b1;
      #1;
      chk("st_rst0", o_stall_cycles, 32'd0);
      i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h77;
      tick();
      i_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("st_five", o_stall_cycles, 32'd5);
      i_ready = 1'b1; i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      #1;
      chk("st_flush", o_stall_cycles, 32'd5);
      i_reset = 1'b0;
      tick();
      i_reset = 1'b1;
      #1;
      chk("st_reset", o_stall_cycles, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
